// File: rtl/ws2811_frame_sequencer_pkg.sv
// rtl/ws2811_frame_sequencer_pkg.sv - shared state encodings, 50MHz timing defaults, counter sizing
//
// Purpose: constants shared by the WS2811 frame sequencer and its bit encoder.
// Ports:   none (package).
package ws2811_frame_sequencer_pkg;

  // Frame FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  // Default timing at a 50MHz clock
  localparam int DEF_NUM_LEDS     = 200;
  localparam int DEF_BIT_CYCLES   = 63;    // 1.26us bit slot
  localparam int DEF_T0H_CYCLES   = 13;
  localparam int DEF_T1H_CYCLES   = 30;
  localparam int DEF_LATCH_CYCLES = 2600;  // 52us latch

  localparam int RGB_W = 24;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ws2811_bit_encoder.sv
// rtl/ws2811_bit_encoder.sv - times one WS2811 bit slot as a high/low pulse
//
// Purpose: owns the slot cycle counter. A load starts a fresh slot on the next
//          cycle; without another load the encoder goes quiet with line low.
// Ports:
//   clock, reset  in   clock and synchronous active-high reset
//   tx_bit        in   value of the bit whose slot starts after this edge
//   load          in   start a new slot on the next cycle
//   line          out  registered serial line
//   slot_last     out  high in the last cycle of the active slot
module ws2811_bit_encoder
  import ws2811_frame_sequencer_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int T0H_CYCLES = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES = DEF_T1H_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic tx_bit,
  input  logic load,
  output logic line,
  output logic slot_last
);

  localparam int CW = cnt_width(BIT_CYCLES);
  localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0H      = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H      = CW'(T1H_CYCLES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          active;
  logic          hold_bit;

  assign cnt_next  = cnt + CW'(1);
  assign slot_last = active && (cnt == LAST_CYC);

  // line is computed one cycle ahead from cnt_next so it stays a plain register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      active   <= 1'b0;
      hold_bit <= 1'b0;
      line     <= 1'b0;
    end else if (load) begin
      cnt      <= '0;
      active   <= 1'b1;
      hold_bit <= tx_bit;
      line     <= 1'b1;
    end else if (slot_last) begin
      cnt    <= '0;
      active <= 1'b0;
      line   <= 1'b0;
    end else if (active) begin
      cnt  <= cnt_next;
      line <= hold_bit ? (cnt_next < T1H) : (cnt_next < T0H);
    end
  end

endmodule

// File: rtl/ws2811_frame_sequencer.sv
// rtl/ws2811_frame_sequencer.sv - WS2811 frame controller: fetch colours, serialise, latch
//
// Purpose: pulls one 24-bit colour per LED from the wave provider, sends it MSB
//          first as timed pulses, then holds the line low for the latch period.
// Ports:
//   clock, reset  in   clock and synchronous active-high reset
//   start         in   begin one frame (IDLE only)
//   continuous    in   chain the next frame straight after the latch
//   rgb[23:0]     in   colour of the current LED from the provider
//   advance       out  1-cycle pulse: rgb captured, provider steps
//   serial_reset  out  high through the latch; provider rewinds
//   data_out      out  WS2811 serial line
//   busy          out  frame in progress
//   frame_done    out  1-cycle pulse after the latch
module ws2811_frame_sequencer
  import ws2811_frame_sequencer_pkg::*;
#(
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic [RGB_W-1:0] rgb,
  output logic             advance,
  output logic             serial_reset,
  output logic             data_out,
  output logic             busy,
  output logic             frame_done
);

  localparam int LEDW = cnt_width(NUM_LEDS);
  localparam int LW   = cnt_width(LATCH_CYCLES);
  localparam logic [LEDW-1:0] LAST_LED   = LEDW'(NUM_LEDS - 1);
  localparam logic [LW-1:0]   LAST_LATCH = LW'(LATCH_CYCLES - 1);

  logic [1:0]       state;
  // The MSB of each colour goes straight to the encoder at capture, so only
  // the remaining 23 bits are held here.
  logic [22:0]      shift;
  logic [4:0]       bit_cnt;
  logic [LEDW-1:0]  led_cnt;
  logic [LW-1:0]    latch_cnt;

  logic load;
  logic tx_bit;
  logic slot_last;
  logic latch_end;

  assign latch_end = (latch_cnt == LAST_LATCH);

  // Load the encoder in the cycle before each slot so slots run back to back.
  always_comb begin
    load   = 1'b0;
    tx_bit = 1'b0;
    case (state)
      ST_IDLE: begin
        load   = start;
        tx_bit = rgb[23];
      end
      ST_SEND: begin
        if (slot_last) begin
          if (bit_cnt != 5'd0) begin
            load   = 1'b1;
            tx_bit = shift[22];
          end else if (led_cnt < LAST_LED) begin
            load   = 1'b1;
            tx_bit = rgb[23];
          end
        end
      end
      ST_LATCH: begin
        load   = latch_end && continuous;
        tx_bit = rgb[23];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      shift        <= '0;
      bit_cnt      <= '0;
      led_cnt      <= '0;
      latch_cnt    <= '0;
      advance      <= 1'b0;
      serial_reset <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      advance    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SEND;
            shift   <= rgb[22:0];
            bit_cnt <= 5'd23;
            led_cnt <= '0;
            advance <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_SEND: begin
          if (slot_last) begin
            if (bit_cnt != 5'd0) begin
              shift   <= {shift[21:0], 1'b0};
              bit_cnt <= bit_cnt - 5'd1;
            end else if (led_cnt < LAST_LED) begin
              shift   <= rgb[22:0];
              bit_cnt <= 5'd23;
              led_cnt <= led_cnt + LEDW'(1);
              advance <= 1'b1;
            end else begin
              state        <= ST_LATCH;
              serial_reset <= 1'b1;
              latch_cnt    <= '0;
            end
          end
        end
        ST_LATCH: begin
          if (latch_end) begin
            serial_reset <= 1'b0;
            frame_done   <= 1'b1;
            latch_cnt    <= '0;
            if (continuous) begin
              state   <= ST_SEND;
              shift   <= rgb[22:0];
              bit_cnt <= 5'd23;
              led_cnt <= '0;
              advance <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            latch_cnt <= latch_cnt + LW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ws2811_bit_encoder #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) u_bit_encoder (
    .clock     (clock),
    .reset     (reset),
    .tx_bit    (tx_bit),
    .load      (load),
    .line      (data_out),
    .slot_last (slot_last)
  );

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// tb/tb_ws2811_frame_sequencer.sv - scoreboard bench for the WS2811 frame sequencer
module tb_ws2811_frame_sequencer;

  localparam int NL    = 3;
  localparam int SLOT  = 63;
  localparam int LATCH = 2600;
  localparam int LEDT  = 24 * SLOT;          // 1512
  localparam int FRAME = NL * LEDT;          // 4536
  localparam int FULL  = FRAME + LATCH;      // 7136

  logic        clock;
  logic        reset;
  logic        start;
  logic        continuous;
  logic [23:0] rgb;
  logic        advance;
  logic        serial_reset;
  logic        data_out;
  logic        busy;
  logic        frame_done;

  ws2811_frame_sequencer #(.NUM_LEDS(NL)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .continuous   (continuous),
    .rgb          (rgb),
    .advance      (advance),
    .serial_reset (serial_reset),
    .data_out     (data_out),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Provider model: steps on advance, rewinds on serial_reset.
  logic [23:0] pal [4];
  int          pidx = 0;
  always @(posedge clock) begin
    if (reset || serial_reset) pidx <= 0;
    else if (advance)          pidx <= pidx + 1;
  end
  assign rgb = pal[pidx[1:0]];

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  logic [23:0] exp_q [$];
  int adv_times [$];
  int first_rise [$];
  int sr_rise [$];
  int sr_len [$];
  int fd_times [$];
  int busy_fall [$];

  // Monitor and decoder
  logic        in_hi = 1'b0;
  logic        prev_ok = 1'b0;
  logic        prev_sr = 1'b0;
  logic        prev_busy = 1'b0;
  int          rise_t = 0;
  int          nbits = 0;
  logic [23:0] acc = '0;

  always @(negedge clock) begin
    int   w;
    logic b;
    if (reset) begin
      in_hi = 1'b0; prev_ok = 1'b0; prev_sr = 1'b0; prev_busy = 1'b0; nbits = 0;
    end else begin
      if (advance) begin
        adv_times.push_back(cyc);
        check("adv_sr_overlap", {31'd0, serial_reset}, 0);
      end
      if (serial_reset) check("dout_in_latch", {31'd0, data_out}, 0);
      if (!busy)        check("dout_idle", {31'd0, data_out}, 0);
      if (serial_reset && !prev_sr) sr_rise.push_back(cyc);
      if (!serial_reset && prev_sr && sr_rise.size() > 0) sr_len.push_back(cyc - sr_rise[$]);
      if (frame_done) fd_times.push_back(cyc);
      if (!busy && prev_busy) busy_fall.push_back(cyc);
      if (serial_reset) prev_ok = 1'b0;
      if (data_out && !in_hi) begin
        if (prev_ok) check("slot_period", cyc - rise_t, SLOT);
        else         first_rise.push_back(cyc);
        prev_ok = 1'b1;
        rise_t  = cyc;
        in_hi   = 1'b1;
      end else if (!data_out && in_hi) begin
        in_hi = 1'b0;
        w = cyc - rise_t;
        b = (w > 21);
        check("pulse_width", w, b ? 30 : 13);
        acc = {acc[22:0], b};
        nbits++;
        if (nbits == 24) begin
          nbits = 0;
          if (exp_q.size() == 0) check("rgb_unexpected", {8'd0, acc}, 32'hDEAD_BEEF);
          else                   check("rgb", {8'd0, acc}, {8'd0, exp_q.pop_front()});
        end
      end
      prev_sr   = serial_reset;
      prev_busy = busy;
    end
  end

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    adv_times.delete(); first_rise.delete(); sr_rise.delete();
    sr_len.delete(); fd_times.delete(); busy_fall.delete();
  endtask

  task automatic load_pal(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c,
                          input int frames);
    pal[0] = a; pal[1] = b; pal[2] = c; pal[3] = 24'h5A5A5A;
    repeat (frames) begin
      exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
    end
  endtask

  task automatic start_frame(output int s);
    @(negedge clock);
    start = 1'b1;
    s = cyc + 1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_fd(input int n);
    int t = 0;
    while (fd_times.size() < n && t < 16000) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);
    check("fd_wait", fd_times.size(), n);
  endtask

  task automatic check_frame(input int s);
    check("adv_count", adv_times.size(), NL);
    for (int i = 0; i < NL; i++) check("adv_time", at(adv_times, i), s + LEDT * i);
    check("first_high", at(first_rise, 0), s);
    check("sr_start", at(sr_rise, 0), s + FRAME);
    check("sr_len", at(sr_len, 0), LATCH);
    check("fd_time", at(fd_times, 0), s + FULL);
    check("fd_count", fd_times.size(), 1);
    check("busy_fall", at(busy_fall, 0), s + FULL);
    check("rgb_left", exp_q.size(), 0);
  endtask

  initial begin
    int s;
    reset = 1'b1; start = 1'b1; continuous = 1'b0;
    pal[0] = '0; pal[1] = '0; pal[2] = '0; pal[3] = '0;

    // 1: reset held with start high
    repeat (5) begin
      @(negedge clock);
      check("reset_outs", {27'd0, advance, serial_reset, data_out, busy, frame_done}, 0);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    check("post_reset_outs", {27'd0, advance, serial_reset, data_out, busy, frame_done}, 0);
    repeat (5) @(negedge clock);
    check("no_adv_after_reset", adv_times.size(), 0);

    // 2 + 3: single frame, first colour 800000
    clear_logs();
    load_pal(24'h800000, 24'hA5F00F, 24'h000001, 1);
    start_frame(s);
    check("busy_at_start", {31'd0, busy}, 1);
    wait_fd(1);
    check_frame(s);

    // 4: two chained frames
    repeat (3) @(negedge clock);
    clear_logs();
    load_pal(24'h123456, 24'hFFFFFF, 24'h000000, 2);
    continuous = 1'b1;
    start_frame(s);
    wait_fd(1);
    continuous = 1'b0;
    wait_fd(2);
    check("cont_adv_count", adv_times.size(), 2 * NL);
    check("cont_second_high", at(first_rise, 1), s + FULL);
    check("cont_second_adv", at(adv_times, NL), s + FULL);
    check("cont_fd1", at(fd_times, 1), s + 2 * FULL);
    check("cont_busy_fall", busy_fall.size(), 1);
    check("cont_busy_fall_t", at(busy_fall, 0), s + 2 * FULL);
    check("cont_rgb_left", exp_q.size(), 0);

    // 5: reset mid-frame, then a clean frame
    repeat (3) @(negedge clock);
    clear_logs();
    load_pal(24'h0F0F0F, 24'hF0F0F0, 24'h3C3C3C, 1);
    start_frame(s);
    repeat (2000) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_dout", {31'd0, data_out}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_sr", {31'd0, serial_reset}, 0);
    reset = 1'b0;
    exp_q.delete();
    clear_logs();
    load_pal(24'hC0FFEE, 24'h00FF00, 24'h7E0001, 1);
    start_frame(s);
    wait_fd(1);
    check_frame(s);

    // 6: start pulses while busy are ignored
    repeat (3) @(negedge clock);
    clear_logs();
    load_pal(24'($urandom), 24'($urandom), 24'($urandom), 1);
    start_frame(s);
    repeat (98) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2898) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_fd(1);
    repeat (20) @(negedge clock);
    check_frame(s);
    check("busy_idle_end", {31'd0, busy}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
